// File: rtl/hex_scan_pkg.sv
// hex_scan_pkg: shared types and limits for the seven-segment scanner.
//   NDIG_MAX    : largest supported digit count
//   digit_idx_t : digit index (0..NDIG_MAX-1)
//   nibble_t    : one hex digit routed to the segment decoder
package hex_scan_pkg;

  localparam int unsigned NDIG_MAX = 8;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/hex_scan_timer.sv
// hex_scan_timer: slot counter (cnt) and digit index (idx) for the scanner.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   show_o      : next cycle lies in the SHOW phase of its slot
//   idx_o       : digit index the next cycle belongs to
//   frame_end_o : registered; high on the last cycle of a frame
// show_o/idx_o look one cycle ahead so the top level can register its outputs
// and still have them line up with the counter state.
module hex_scan_timer
  import hex_scan_pkg::*;
#(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       show_o,
  output digit_idx_t idx_o,
  output logic       frame_end_o
);

  localparam int unsigned CntW = $clog2(DWELL);

  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic            frame_q, frame_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(DWELL - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == digit_idx_t'(NDIG - 1)) ? digit_idx_t'(0) : idx_q + digit_idx_t'(1);
    end
    frame_d = (cnt_d == CntW'(DWELL - 1)) && (idx_d == digit_idx_t'(NDIG - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign show_o      = (cnt_d >= CntW'(BLANK));
  assign idx_o       = idx_d;
  assign frame_end_o = frame_q;

endmodule

// File: rtl/hex_scan.sv
// hex_scan: time-multiplexed scanner for common-anode seven-segment digits.
// Holds an active display word plus a one-deep shadow for pending loads;
// shadow is promoted only at frame boundaries so a frame never tears.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   load_valid_i : load_data_i is valid
//   load_data_i  : display word, nibble k is digit k (digit 0 rightmost)
//   load_ready_o : shadow register is free
//   dig_o        : nibble for the current digit (to the hex decoder)
//   an_o         : one-hot digit enable, active-high
//   frame_o      : one-cycle pulse on the last cycle of each frame
// Build option: define HEX_SCAN_LZB_EN for leading-zero blanking.
module hex_scan
  import hex_scan_pkg::*;
#(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [4*NDIG-1:0] load_data_i,
  output logic              load_ready_o,
  output logic [3:0]        dig_o,
  output logic [NDIG-1:0]   an_o,
  output logic              frame_o
);

  logic       show_nxt;
  digit_idx_t idx_nxt;
  logic       frame_end;

  hex_scan_timer #(
    .NDIG  (NDIG),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .show_o      (show_nxt),
    .idx_o       (idx_nxt),
    .frame_end_o (frame_end)
  );

  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              ready_q, ready_d;  // ready == ~pending
  nibble_t           dig_q, dig_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [NDIG-1:0]   mask_nxt;

  // Transfer and promotion are mutually exclusive: transfer needs ready=1,
  // promotion needs ready=0. A load on the boundary cycle waits a frame.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    if (load_valid_i && ready_q) begin
      shadow_d = load_data_i;
      ready_d  = 1'b0;
    end
    if (frame_end && !ready_q) begin
      active_d = shadow_q;
      ready_d  = 1'b1;
    end
    dig_d = active_d[int'(idx_nxt)*4 +: 4];
  end

`ifdef HEX_SCAN_LZB_EN
  logic [NDIG-1:0] mask_q, mask_d;

  // Mask every digit above the highest nonzero nibble; digit 0 always shows.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    mask_d = mask_q;
    if (frame_end) begin
      mask_d = '0;
      for (int k = int'(NDIG) - 1; k >= 1; k--) begin
        if (active_d[k*4 +: 4] != 4'h0) seen = 1'b1;
        mask_d[k] = ~seen;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign mask_nxt = mask_d;
`else
  assign mask_nxt = '0;
`endif

  always_comb begin
    an_d = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      an_d[k] = show_nxt && (idx_nxt == digit_idx_t'(k)) && !mask_nxt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      dig_q    <= '0;
      an_q     <= '0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      dig_q    <= dig_d;
      an_q     <= an_d;
    end
  end

  assign load_ready_o = ready_q;
  assign dig_o        = dig_q;
  assign an_o         = an_q;
  assign frame_o      = frame_end;

endmodule

// File: tb/tb_hex_scan.sv
// tb_hex_scan: directed self-checking bench for hex_scan.
// Main instance NDIG=8/DWELL=8/BLANK=2, second instance NDIG=1/DWELL=4/BLANK=1.
module tb_hex_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic [3:0]  dig;
  logic [7:0]  an;
  logic        frame;

  logic        valid1;
  logic [3:0]  data1;
  logic        ready1;
  logic [3:0]  dig1;
  logic [0:0]  an1;
  logic        frame1;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [7:0] mask_a05;
  logic [7:0] mask_zero;

  always #5 clk = ~clk;

  hex_scan #(.NDIG(8), .DWELL(8), .BLANK(2)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (valid),
    .load_data_i  (data),
    .load_ready_o (ready),
    .dig_o        (dig),
    .an_o         (an),
    .frame_o      (frame)
  );

  hex_scan #(.NDIG(1), .DWELL(4), .BLANK(1)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (valid1),
    .load_data_i  (data1),
    .load_ready_o (ready1),
    .dig_o        (dig1),
    .an_o         (an1),
    .frame_o      (frame1)
  );

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until frame is high, at most 200 cycles; n = cycles waited.
  task automatic wait_frame();
    n = 0;
    while (frame !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("frame_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Starts on cnt=0 of digit 0; ends on cnt=0 of digit 0 of the next frame.
  task automatic check_frame(input logic [31:0] word, input logic [7:0] mask);
    logic [3:0]  nib;
    logic [31:0] exp_an;
    for (int k = 0; k < 8; k++) begin
      nib    = word[k*4 +: 4];
      exp_an = mask[k] ? 32'd0 : (32'd1 << k);
      chk("dig_blank", {28'd0, dig}, {28'd0, nib});
      chk("an_blank", {24'd0, an}, 32'd0);
      tick(2);
      chk("an_show", {24'd0, an}, exp_an);
      chk("dig_show", {28'd0, dig}, {28'd0, nib});
      tick(5);
      chk("frame_slot_end", {31'd0, frame}, (k == 7) ? 32'd1 : 32'd0);
      tick(1);
    end
  endtask

  initial begin
`ifdef HEX_SCAN_LZB_EN
    mask_a05  = 8'hF8;
    mask_zero = 8'hFE;
`else
    mask_a05  = 8'h00;
    mask_zero = 8'h00;
`endif
    rst    = 1'b1;
    valid  = 1'b0;
    data   = 32'h0;
    valid1 = 1'b0;
    data1  = 4'h0;
    tick(3);
    chk("rst_an", {24'd0, an}, 32'd0);
    chk("rst_dig", {28'd0, dig}, 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    // Run part of a slot, then reset mid-frame for 3 cycles.
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(3);
    chk("midrst_an", {24'd0, an}, 32'd0);
    chk("midrst_dig", {28'd0, dig}, 32'd0);
    chk("midrst_frame", {31'd0, frame}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("first_slot_an", {24'd0, an}, (c < 2) ? 32'd0 : 32'd1);
      tick(1);
    end

    // Load 89ABCDEF right at reset release.
    rst = 1'b1;
    tick(2);
    rst   = 1'b0;
    valid = 1'b1;
    data  = 32'h89ABCDEF;
    chk("load_ready_before", {31'd0, ready}, 32'd1);
    tick(1);
    valid = 1'b0;
    chk("load_ready_drop", {31'd0, ready}, 32'd0);
    chk("load_old_dig", {28'd0, dig}, 32'd0);
    wait_frame();
    chk("first_frame_len", n, 32'd62);
    chk("ready_on_frame", {31'd0, ready}, 32'd0);
    tick(1);
    chk("ready_after_frame", {31'd0, ready}, 32'd1);
    check_frame(32'h89ABCDEF, 8'h00);

    // Hold-off: second word pending, then toggle valid with junk data.
    valid = 1'b1;
    data  = 32'h12345678;
    tick(1);
    chk("holdoff_dig_old", {28'd0, dig}, 32'hF);
    n = 0;
    while (frame !== 1'b1 && n < 200) begin
      chk("holdoff_ready_low", {31'd0, ready}, 32'd0);
      valid = ~valid;
      data  = 32'h11111111;
      tick(1);
      n++;
    end
    chk("holdoff_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    valid = 1'b0;
    chk("holdoff_ready_at_frame", {31'd0, ready}, 32'd0);
    tick(1);
    chk("holdoff_ready_rise", {31'd0, ready}, 32'd1);
    check_frame(32'h12345678, 8'h00);

    // Load accepted on the frame_o cycle takes effect a frame later.
    wait_frame();
    chk("bnd_ready", {31'd0, ready}, 32'd1);
    valid = 1'b1;
    data  = 32'hCAFEBABE;
    tick(1);
    valid = 1'b0;
    chk("bnd_ready_drop", {31'd0, ready}, 32'd0);
    check_frame(32'h12345678, 8'h00);
    check_frame(32'hCAFEBABE, 8'h00);

    // Leading-zero words.
    valid = 1'b1;
    data  = 32'h00000A05;
    tick(1);
    valid = 1'b0;
    wait_frame();
    tick(1);
    check_frame(32'h00000A05, mask_a05);
    valid = 1'b1;
    data  = 32'h00000000;
    tick(1);
    valid = 1'b0;
    wait_frame();
    tick(1);
    check_frame(32'h00000000, mask_zero);

    // Single-digit instance.
    rst = 1'b1;
    tick(2);
    chk("n1_rst_an", {31'd0, an1}, 32'd0);
    chk("n1_rst_ready", {31'd0, ready1}, 32'd1);
    chk("n1_rst_frame", {31'd0, frame1}, 32'd0);
    chk("n1_rst_dig", {28'd0, dig1}, 32'd0);
    rst    = 1'b0;
    valid1 = 1'b1;
    data1  = 4'hA;
    for (int c = 0; c < 12; c++) begin
      chk("n1_an", {31'd0, an1}, ((c % 4) == 0) ? 32'd0 : 32'd1);
      chk("n1_frame", {31'd0, frame1}, ((c % 4) == 3) ? 32'd1 : 32'd0);
      chk("n1_dig", {28'd0, dig1}, (c >= 4) ? 32'hA : 32'h0);
      tick(1);
      valid1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
